// File: rtl/sync_filter_if.sv
// sync_filter_if: per-channel asynchronous inputs and filtered level/edge outputs.
interface sync_filter_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] glitch;
  modport master (output data_in, input data_out, rise, fall, glitch);
  modport slave (input data_in, output data_out, rise, fall, glitch);
endinterface

// File: rtl/sync_filter.sv
// sync_filter: per-channel synchronizer chain followed by a stability filter
// that emits registered rise/fall pulses on accepted edges and glitch on abandoned ones.
module sync_filter #(
  parameter int WIDTH = 1,
  parameter int STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic clk_dst,
  input logic rst_n_dst,
  sync_filter_if.slave bus
);
  localparam int CW = $clog2(FILT_CYCLES + 1);
`ifdef SIMULATION
  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("sync_filter: STAGES must be 2..4");
  end
  if (FILT_CYCLES < 1 || FILT_CYCLES > 256) begin : g_bad_filt
    $error("sync_filter: FILT_CYCLES must be 1..256");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_filter: WIDTH must be >= 1");
  end
`endif
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_sync [STAGES];
  logic [WIDTH-1:0] w_out, w_rise, w_fall, w_glitch;
  always_ff @(posedge clk_dst or negedge rst_n_dst)
    if (!rst_n_dst) begin
      for (int k = 0; k < STAGES; k++) r_sync[k] <= RESET_VAL;
    end else begin
      r_sync[0] <= bus.data_in;
      for (int k = 1; k < STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [CW-1:0] r_cnt;
    logic r_out, r_rise, r_fall, r_glitch;
    logic w_s, w_diff, w_done;
    assign w_s = r_sync[STAGES-1][i];
    assign w_diff = w_s ^ r_out;
    // r_cnt counts earlier cycles of the current candidate, so acceptance is at FILT_CYCLES-1
    assign w_done = w_diff && r_cnt == CW'(FILT_CYCLES - 1);
    always_ff @(posedge clk_dst or negedge rst_n_dst)
      if (!rst_n_dst) begin
        r_cnt <= '0;
        r_out <= RESET_VAL[i];
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        r_glitch <= 1'b0;
      end else begin
        r_cnt <= (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
        r_out <= w_done ? w_s : r_out;
        r_rise <= w_done && w_s;
        r_fall <= w_done && !w_s;
        r_glitch <= !w_diff && r_cnt != '0;
      end
    assign w_out[i] = r_out;
    assign w_rise[i] = r_rise;
    assign w_fall[i] = r_fall;
    assign w_glitch[i] = r_glitch;
  end
  assign bus.data_out = w_out;
  assign bus.rise = w_rise;
  assign bus.fall = w_fall;
  assign bus.glitch = w_glitch;
endmodule

// File: tb/tb_sync_filter.sv
// tb_sync_filter: two configurations (filtered 4-channel, bypass 2-channel) checked
// cycle by cycle against a run-length reference model through a scoreboard.
module tb_sync_filter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] din_a;
  logic [1:0] din_b;
  always #5 clk = ~clk;
  sync_filter_if #(.WIDTH(4)) if_a ();
  sync_filter_if #(.WIDTH(2)) if_b ();
  assign if_a.data_in = din_a;
  assign if_b.data_in = din_b;
  sync_filter #(.WIDTH(4), .STAGES(2), .FILT_CYCLES(4), .RESET_VAL(4'b0101)) dut_a (
    .clk_dst(clk), .rst_n_dst(rst_n), .bus(if_a.slave));
  sync_filter #(.WIDTH(2), .STAGES(3), .FILT_CYCLES(1), .RESET_VAL(2'b10)) dut_b (
    .clk_dst(clk), .rst_n_dst(rst_n), .bus(if_b.slave));
  localparam logic [3:0] RV_A = 4'b0101;
  localparam logic [3:0] RV_B = 4'b0010;
  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] exp_q [2][$];
  logic [3:0] chain [2][$];
  logic [3:0] m_out [2];
  bit shist [2][4][$];
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] dut_vec(input int k);
    return k == 0 ? {if_a.data_out, if_a.rise, if_a.fall, if_a.glitch}
                  : {2'b0, if_b.data_out, 2'b0, if_b.rise, 2'b0, if_b.fall, 2'b0, if_b.glitch};
  endfunction
  // A new level is accepted once it has been seen FILT consecutive cycles after the
  // delay line; a run that ends early is a glitch reported when the level reverts.
  task automatic model_step(input int k, input int st, input int fc, input logic [3:0] rv,
                            input logic [3:0] din, input bit rst);
    logic [3:0] s;
    logic [3:0] r = '0, f = '0, g = '0;
    int run, n;
    if (rst) begin
      chain[k].delete();
      repeat (st) chain[k].push_back(rv);
      m_out[k] = rv;
      for (int c = 0; c < 4; c++) shist[k][c].delete();
      exp_q[k].push_back({rv, 12'h000});
      return;
    end
    s = chain[k].pop_front();
    chain[k].push_back(din);
    for (int c = 0; c < 4; c++) begin
      shist[k][c].push_back(s[c]);
      if (shist[k][c].size() > fc + 1) void'(shist[k][c].pop_front());
      n = shist[k][c].size();
      run = 0;
      for (int j = n - 1; j >= 0 && shist[k][c][j] != m_out[k][c]; j--) run++;
      if (run >= fc) begin
        m_out[k][c] = s[c];
        r[c] = s[c];
        f[c] = !s[c];
      end else if (run == 0 && n > 1 && shist[k][c][n-2] != m_out[k][c]) g[c] = 1'b1;
    end
    exp_q[k].push_back({m_out[k], r, f, g});
  endtask
  always @(posedge clk) begin
    model_step(0, 2, 4, RV_A, din_a, !rst_n);
    model_step(1, 3, 1, RV_B, {2'b00, din_b}, !rst_n);
  end
  always @(posedge clk) begin
    logic [15:0] v;
    #1;
    for (int k = 0; k < 2; k++) begin
      v = dut_vec(k);
      if (exp_q[k].size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty dut%0d: got %h expected queued entry", k, v);
      end else check($sformatf("dut%0d", k), v, exp_q[k].pop_front());
      check($sformatf("exclusive dut%0d", k),
            {12'h000, (v[11:8] & v[7:4]) | (v[11:8] & v[3:0]) | (v[7:4] & v[3:0])}, 16'h0000);
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    din_a = 4'b0000;
    din_b = 2'b10;
    cyc(3);
    #1;
    check("reset_a", dut_vec(0), {RV_A, 12'h000});
    check("reset_b", dut_vec(1), {RV_B, 12'h000});
    cyc(1);
    rst_n = 1'b1;
    cyc(12);
    din_a[0] = 1'b1; cyc(10);
    din_a[0] = 1'b0; cyc(10);
    din_a[0] = 1'b1; cyc(3);
    din_a[0] = 1'b0; cyc(10);
    din_a[0] = 1'b1; cyc(4);
    din_a[0] = 1'b0; cyc(12);
    for (int i = 0; i < 12; i++) begin
      din_b[0] = ~din_b[0];
      cyc(2);
    end
    cyc(6);
    din_a[0] = 1'b1;
    cyc(4);
    rst_n = 1'b0;
    din_a = RV_A;
    din_b = RV_B[1:0];
    #1;
    check("reset_mid_a", dut_vec(0), {RV_A, 12'h000});
    check("reset_mid_b", dut_vec(1), {RV_B, 12'h000});
    cyc(2);
    rst_n = 1'b1;
    cyc(20);
    for (int i = 0; i < 400; i++) begin
      din_a = din_a ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
      din_b = din_b ^ (2'($urandom) & 2'($urandom));
      if (i == 200) rst_n = 1'b0;
      if (i == 203) rst_n = 1'b1;
      cyc(1);
    end
    cyc(10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_filter.md
# sync_filter

Multi-channel, parametrised successor to the single-bit synchronizer. Each of WIDTH independent asynchronous inputs passes through a STAGES-deep flip-flop chain into the destination clock domain. A per-channel glitch filter then requires the synchronized value to be stable for FILT_CYCLES cycles before it is accepted. Qualified transitions produce registered rise/fall pulses, and rejected transitions produce a glitch pulse. It sits at the UART pin boundary (RX, CTS, break/status inputs) and feeds the receiver FSM and interrupt logic directly.

## Interface
- WIDTH, 1: number of independent channels; ≥1.
- STAGES, 2: synchronizer flops per channel; legal 2..4.
- FILT_CYCLES, 4: consecutive cycles a new synchronized value must hold before acceptance; legal 1..256; 1 = no filtering.
- RESET_VAL, '0 (WIDTH bits): per-channel reset/idle level (UART RX channel uses 1).
- clk_dst  input  1  destination clock; the only clock.
- rst_n_dst  input  1  reset, asynchronous assert, active-low.
- data_in  input  WIDTH  asynchronous inputs, one bit per channel.
- data_out  output  WIDTH  synchronized, filtered level.
- rise  output  WIDTH  one-cycle pulse: data_out[i] went 0→1 this cycle.
- fall  output  WIDTH  one-cycle pulse: data_out[i] went 1→0 this cycle.
- glitch  output  WIDTH  one-cycle pulse: a candidate transition was abandoned before qualifying.

## Operation
- Channels are fully independent. There is no cross-channel coherency, so the block must not be used for multi-bit buses.
- Sync chain: shift register of STAGES flops, marked ASYNC_REG. It resets to RESET_VAL[i]. Its last stage is s[i].
- Filter counter cnt[i], width $clog2(FILT_CYCLES+1), resets to 0. On each clk_dst edge:
  - s==data_out, cnt==0: hold.
  - s==data_out, cnt!=0: cnt<=0; glitch<=1.
  - s!=data_out, cnt<FILT_CYCLES-1: cnt<=cnt+1.
  - s!=data_out, cnt==FILT_CYCLES-1: data_out<=s; cnt<=0; rise<=s or fall<=~s.
- rise, fall and glitch are registered. On any edge where they are not set as above, they clear to 0. rise/fall are high exactly in the first cycle data_out shows its new value.
- rise, fall and glitch are mutually exclusive per channel. At most one of them is high in any cycle.
- FILT_CYCLES=1: the counter is always 0 at compare, so data_out follows s with one extra cycle of delay and glitch never asserts.
- Reset, any time including mid-count: all chain flops and data_out = RESET_VAL; cnt = 0; rise/fall/glitch = 0.
- After reset release, if data_in differs from RESET_VAL, this is treated as a normal transition. It is filtered and produces a rise/fall pulse.
- Elaboration checks, under `ifdef SIMULATION`: STAGES outside 2..4, FILT_CYCLES outside 1..256 or WIDTH<1 → $error.

## Timing
- Reset values: data_out=RESET_VAL; rise=fall=glitch=0.
- Latency for a clean step: a data_in change sampled at edge 1 appears on data_out, with its rise/fall pulse, after edge STAGES+FILT_CYCLES. At defaults that is 6 edges.
- Acceptance threshold: a pulse seen at s for ≥FILT_CYCLES consecutive cycles is accepted. A pulse seen for k<FILT_CYCLES cycles is rejected. Its glitch pulse appears one cycle after s reverts, i.e. STAGES+k+1 edges after the pulse was sampled.
- An accepted pulse of k cycles at s yields data_out asserted for exactly k cycles, provided the return edge also holds ≥FILT_CYCLES cycles.
- Pulse outputs are exactly one cycle wide. Back-to-back qualified transitions are at least FILT_CYCLES cycles apart.
- Tolerance: a data_in change within a cycle may be captured one edge earlier or later due to metastability resolution. The bench applies data_in on the inactive clock edge for deterministic counts.

## Test plan
- Reset values: WIDTH=4, RESET_VAL=4'b0101, data_in=0 through reset → data_out=0101, all pulses 0. After release, fall[0] and fall[2] pulse together at edge 6 and data_out=0000.
- Latency: defaults, data_in[0] 0→1 held → data_out[0] rises at exactly edge 6 with one rise[0] pulse. 1→0 held → data_out[0] falls at edge 6 with one fall[0] pulse.
- Glitch reject: FILT_CYCLES=4, 3-cycle high pulse on data_in[0] → data_out[0] stays 0, no rise, glitch[0] pulses once at edge 6.
- Threshold pass: 4-cycle high pulse → data_out[0] high for exactly 4 cycles, rise then fall one cycle each, no glitch.
- Bypass: FILT_CYCLES=1, STAGES=3, data_in toggling every 2 cycles → data_out is the identical waveform delayed 4 edges, rise/fall on every change, glitch never.
- Reset mid-count: assert rst_n_dst=0 while cnt[0]=2 → immediate RESET_VAL, pulses 0. Release with data_in=RESET_VAL → no pulses for 20 cycles.
